// File: rtl/axis_lfsr_pkg.sv
// rtl/axis_lfsr_pkg.sv - shared types and default constants for the LFSR stream source
package axis_lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } lfsr_fsm_e;

  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS_32      = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h0000_0001;

endpackage

// File: rtl/axis_lfsr_if.sv
// rtl/axis_lfsr_if.sv - stream bundle between the LFSR source and its consumer
interface axis_lfsr_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR state register with load, enable and zero-seed guard
module lfsr_core
  import axis_lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_32,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_DEFAULT
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] state_o
);
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] seed_d;

  assign state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
  // An all-zero state would lock up the register, so it is replaced by 1
  assign seed_d  = (load_value_i == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : load_value_i;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= SEED;
    end else if (load_i) begin
      state_q <= seed_d;
    end else if (en_i) begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
endmodule

// File: rtl/axis_lfsr_source.sv
// rtl/axis_lfsr_source.sv - packetised pseudo-random stream source with start/stop/limit control
module axis_lfsr_source
  import axis_lfsr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = LFSR_TAPS_32,
  parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_SEED_DEFAULT,
  parameter int                    PKT_LEN    = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  stop,
  input  logic [15:0]           num_pkts,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_value,
  axis_lfsr_if.master           m_axis,
  output logic                  busy,
  output logic [15:0]           pkt_cnt
);
  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  lfsr_fsm_e             state_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic [15:0]           beat_cnt_q;
  logic [15:0]           beat_cnt_d;
  logic [15:0]           run_pkts_q;
  logic [15:0]           num_pkts_q;
  logic [15:0]           pkt_cnt_q;
  logic [LFSR_WIDTH-1:0] lfsr_state;
  logic                  hs;
  logic                  last_hs;
  logic                  limit_hit;

  assign hs         = tvalid_q & m_axis.tready;
  assign last_hs    = hs & tlast_q;
  assign beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? 16'd0 : beat_cnt_q + 16'd1;
  assign limit_hit  = (num_pkts_q != 16'd0) && (run_pkts_q + 16'd1 == num_pkts_q);

  lfsr_core #(
    .WIDTH(LFSR_WIDTH),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .load_i      ((state_q == ST_IDLE) && seed_load),
    .load_value_i(seed_value),
    .en_i        (hs),
    .state_o     (lfsr_state)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      beat_cnt_q <= 16'd0;
      run_pkts_q <= 16'd0;
      num_pkts_q <= 16'd0;
      pkt_cnt_q  <= 16'd0;
    end else begin
      // Beat bookkeeping only moves on a handshake; tlast is precomputed for the next beat
      if (hs) begin
        beat_cnt_q <= beat_cnt_d;
        tlast_q    <= (beat_cnt_d == LAST_BEAT);
      end
      if (last_hs) begin
        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
        run_pkts_q <= run_pkts_q + 16'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_RUN;
            tvalid_q   <= 1'b1;
            tlast_q    <= (LAST_BEAT == 16'd0);
            beat_cnt_q <= 16'd0;
            run_pkts_q <= 16'd0;
            num_pkts_q <= num_pkts;
          end
        end
        ST_RUN: begin
          if (last_hs && (stop || limit_hit)) begin
            state_q  <= ST_IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
          end else if (stop) begin
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (last_hs) begin
            state_q  <= ST_IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis.tdata  = DATA_WIDTH'(lfsr_state);
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = (state_q != ST_IDLE);
  assign pkt_cnt       = pkt_cnt_q;
endmodule

// File: tb/tb_axis_lfsr_source.sv
// tb/tb_axis_lfsr_source.sv - directed self-checking bench for axis_lfsr_source
module tb_axis_lfsr_source;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic        stop;
  logic [15:0] num_pkts;
  logic        seed_load;
  logic [31:0] seed_value;
  logic        busy;
  logic [15:0] pkt_cnt;

  always #5 aclk = ~aclk;

  axis_lfsr_if #(.DATA_WIDTH(32)) m_axis ();

  axis_lfsr_source #(
    .DATA_WIDTH(32),
    .LFSR_WIDTH(32),
    .TAPS      (32'h8020_0003),
    .SEED      (32'h0000_0001),
    .PKT_LEN   (16)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .stop      (stop),
    .num_pkts  (num_pkts),
    .seed_load (seed_load),
    .seed_value(seed_value),
    .m_axis    (m_axis),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_state;
  int          m_beat;
  int          m_pkts;
  logic [31:0] seen[$];

  function automatic logic [31:0] mnext(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    m_state = 32'h1;
    m_beat  = 0;
    m_pkts  = 0;
  endtask

  task automatic start_run(input logic [15:0] n, input string tag);
    num_pkts = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    m_beat   = 0;
    n_checks++;
    if (m_axis.tvalid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start_latency tvalid=%b busy=%b expected 1/1", tag, m_axis.tvalid, busy);
    end
  endtask

  task automatic collect(input int nbeats, input bit rnd, input int stop_at, input string tag);
    int   got = 0;
    int   cyc = 0;
    logic rdy;
    seen.delete();
    while (got < nbeats && cyc < 1000) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis.tready = rdy;
      stop = (got == stop_at);
      n_checks++;
      if (m_axis.tvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_tvalid beat=%0d got=%b expected 1", tag, got, m_axis.tvalid);
      end
      n_checks++;
      if (m_axis.tdata !== m_state) begin
        n_fail++;
        $display("FAIL %s_tdata beat=%0d got=%h expected %h", tag, got, m_axis.tdata, m_state);
      end
      n_checks++;
      if (m_axis.tlast !== (m_beat == 15)) begin
        n_fail++;
        $display("FAIL %s_tlast beat=%0d got=%b expected %b", tag, got, m_axis.tlast, (m_beat == 15));
      end
      if (rdy) begin
        seen.push_back(m_axis.tdata);
        if (m_beat == 15) m_pkts++;
        m_state = mnext(m_state);
        m_beat  = (m_beat + 1) % 16;
        got++;
      end
      tick();
      cyc++;
    end
    stop = 1'b0;
    n_checks++;
    if (got != nbeats) begin
      n_fail++;
      $display("FAIL %s_timeout beats=%0d expected %0d", tag, got, nbeats);
    end
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if (m_axis.tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle tvalid=%b busy=%b expected 0/0", tag, m_axis.tvalid, busy);
    end
    n_checks++;
    if (pkt_cnt !== 16'(m_pkts)) begin
      n_fail++;
      $display("FAIL %s_pkt_cnt got=%0d expected %0d", tag, pkt_cnt, m_pkts);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (m_axis.tvalid !== 1'b0 || m_axis.tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_last tvalid=%b tlast=%b expected 0/0", m_axis.tvalid, m_axis.tlast);
    end
    n_checks++;
    if (m_axis.tdata !== 32'h1) begin
      n_fail++;
      $display("FAIL reset_tdata got=%h expected 00000001", m_axis.tdata);
    end
    n_checks++;
    if (busy !== 1'b0 || pkt_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_busy_cnt busy=%b pkt_cnt=%0d expected 0/0", busy, pkt_cnt);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp4 [4];
    exp4 = '{32'h1, 32'h3, 32'h6, 32'hD};
    seed_load  = 1'b1;
    seed_value = 32'h1;
    start_run(16'd1, "basic");
    seed_load  = 1'b0;
    collect(16, 1'b0, -1, "basic");
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (seen[i] !== exp4[i]) begin
        n_fail++;
        $display("FAIL basic_seq%0d got=%h expected %h", i, seen[i], exp4[i]);
      end
    end
    n_checks++;
    if (pkt_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_pkt_cnt got=%0d expected 1", pkt_cnt);
    end
    check_idle("basic");
  endtask

  task automatic test_backpressure();
    start_run(16'd2, "bp");
    collect(32, 1'b1, -1, "bp");
    check_idle("bp");
  endtask

  task automatic test_seed();
    seed_load  = 1'b1;
    seed_value = 32'h0;
    tick();
    seed_load  = 1'b0;
    m_state    = 32'h1;
    n_checks++;
    if (m_axis.tdata !== 32'h1) begin
      n_fail++;
      $display("FAIL seed_zero got=%h expected 00000001", m_axis.tdata);
    end
    seed_load  = 1'b1;
    seed_value = 32'h0000_ABCD;
    start_run(16'd1, "seed");
    m_state    = 32'h0000_ABCD;
    seed_value = 32'hDEAD_BEEF;
    collect(16, 1'b0, -1, "seed_run");
    seed_load  = 1'b0;
    n_checks++;
    if (seen[0] !== 32'h0000_ABCD) begin
      n_fail++;
      $display("FAIL seed_first_beat got=%h expected 0000abcd", seen[0]);
    end
    check_idle("seed");
  endtask

  task automatic test_limit();
    do_reset();
    start_run(16'd3, "limit");
    collect(48, 1'b0, -1, "limit");
    n_checks++;
    if (pkt_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL limit_pkt_cnt got=%0d expected 3", pkt_cnt);
    end
    check_idle("limit");
  endtask

  task automatic test_stop();
    start_run(16'd0, "stop_mid");
    collect(16, 1'b0, 4, "stop_mid");
    check_idle("stop_mid");
    start_run(16'd0, "stop_last");
    collect(16, 1'b0, 15, "stop_last");
    check_idle("stop_last");
  endtask

  task automatic test_reset_mid();
    start_run(16'd0, "rst_mid");
    collect(5, 1'b0, -1, "rst_mid");
    m_axis.tready = 1'b0;
    aresetn = 1'b0;
    tick();
    n_checks++;
    if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== 32'h1) begin
      n_fail++;
      $display("FAIL rst_mid_out tvalid=%b tdata=%h expected 0/00000001", m_axis.tvalid, m_axis.tdata);
    end
    n_checks++;
    if (pkt_cnt !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state pkt_cnt=%0d busy=%b expected 0/0", pkt_cnt, busy);
    end
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    aresetn       = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    num_pkts      = 16'd0;
    seed_load     = 1'b0;
    seed_value    = 32'h0;
    m_axis.tready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_seed();
    test_limit();
    test_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_lfsr_source.md
# axis_lfsr_source

AXI-Stream pseudo-random data source feeding `axi_stream_fifo` slave port in the AXI_LFSR path. Generates a Fibonacci LFSR sequence, frames it into fixed-length packets with `tlast`, and honours full AXI-Stream backpressure. A small control FSM handles start, stop and seed loading, plus an optional packet-count limit.

## Interface
- `DATA_WIDTH`, 32: `m_axis_tdata` width; must equal `LFSR_WIDTH`.
- `LFSR_WIDTH`, 32: LFSR state width.
- `TAPS`, 32'h80200003: feedback mask (x^32+x^22+x^2+x+1); bit i set means state[i] enters feedback.
- `SEED`, 32'h00000001: state loaded at reset.
- `PKT_LEN`, 16: beats per packet, ≥1.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `start`  in  1  pulse: begin generation (sampled in IDLE only).
- `stop`  in  1  pulse: finish current packet, then return to IDLE.
- `num_pkts`  in  16  packets per run, sampled on start; 0 = unlimited.
- `seed_load`  in  1  load `seed_value` into LFSR (IDLE only).
- `seed_value`  in  LFSR_WIDTH  new seed; 0 is replaced by 1.
- `m_axis_tdata`  out  DATA_WIDTH  current LFSR state.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tlast`  out  1  last beat of packet.
- `m_axis_tready`  in  1  downstream ready (FIFO `s_axis_tready`).
- `busy`  out  1  FSM not in IDLE.
- `pkt_cnt`  out  16  completed packets since reset, wraps 0xFFFF→0.

## Operation
- States: IDLE, RUN, FINISH.
  - IDLE: tvalid=0. `start` moves to RUN and clears `beat_cnt` and `run_pkts`.
  - RUN: tvalid=1. Each handshake (tvalid&&tready) advances LFSR and beat_cnt. `stop`, or a tlast handshake that makes run_pkts==num_pkts (num_pkts≠0), moves to FINISH or IDLE as below.
  - FINISH: tvalid=1 until tlast handshake, then IDLE.
  - `stop` arriving mid-packet goes to FINISH. `stop` arriving on the same cycle as a tlast handshake goes directly to IDLE.
  - Reaching the limit always goes directly to IDLE.
- LFSR next state = {state[W-2:0], ^(state & TAPS)}. The state holds when no handshake occurs.
- tdata = state, registered.
- beat_cnt runs 0..PKT_LEN-1 and wraps. tlast = (beat_cnt==PKT_LEN-1). PKT_LEN=1 gives tlast on every beat.
- pkt_cnt and run_pkts increment on each tlast handshake.
- `seed_load` outside IDLE is ignored. `start` outside IDLE is ignored. `stop` in IDLE is ignored.
- LFSR state persists across runs; a new run continues the sequence unless a seed is reloaded.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=SEED, busy=0, pkt_cnt=0, FSM=IDLE, beat_cnt=0.
- Reset mid-packet aborts immediately. A partial packet is not completed.
- `start` at cycle N: tvalid=1 and busy=1 at N+1.
- `seed_load` and `start` in the same cycle: the seed is loaded and the first beat carries the new seed.
- Throughput is 1 beat/clk while tready=1. After a handshake at edge N, the next tdata/tlast are valid at N+1 with no bubble.
- AXI rule: once tvalid=1, tvalid, tdata and tlast stay stable until the handshake. `stop` never drops tvalid mid-beat.
- tvalid falls the cycle after the final tlast handshake. busy falls in the same cycle.
- No combinational path from tready to any output.

## Structure
- Package `axis_lfsr_pkg` holds:
  - the state enum (IDLE/RUN/FINISH);
  - default constants `LFSR_TAPS_32`, `LFSR_SEED_DEFAULT`.
- Sub-module `lfsr_core` holds the state register with load, enable and zero-seed guard, and outputs state. It is reused by a future checker block.
- The top holds the FSM, the counters and the AXI output.

## Test plan
- Reset, seed_load 1, start with tready=1: tdata sequence 0x1, 0x3, 0x6, 0xD. tlast on beat 16. pkt_cnt=1 after beat 16.
- tready toggles pseudo-randomly: tdata and tlast are held while stalled, no beat is lost or duplicated, and the sequence matches the model.
- num_pkts=3, tready=1: exactly 48 beats. tvalid=0 the cycle after the 3rd tlast. busy=0 and pkt_cnt=3.
- `stop` at beat 5 of a packet: remaining beats 6–16 are delivered, then IDLE. `stop` coincident with a tlast handshake goes to IDLE with no extra beat.
- seed_load with seed_value=0: first beat is 0x1. seed_load during RUN is ignored and the sequence is unchanged.
- aresetn low mid-packet with tready=0: the next cycle shows tvalid=0, tdata=SEED and pkt_cnt=0. Connected to `axi_stream_fifo` (DEPTH=16), the FIFO output sequence matches the model.
